// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slew-rate limiter that sits in front of the 8-bit PWM generator.
// A target duty is captured from the motion controller, clamped to MAX_DUTY, and
// the registered duty walks toward it by STEP every TICK_DIV clocks. An active-low
// emergency stop forces duty and target to zero for as long as it is held.
module pwm_duty_ramp #(
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 2,
  parameter int MAX_DUTY = 249
) (
  input  logic       clock,
  input  logic       reset_InLow,
  input  logic       target_valid,
  input  logic [7:0] target_duty,
  input  logic       estop_InLow,
  output logic [7:0] duty_out,
  output logic       busy,
  output logic       done
);

  // Divider width covers 0..TICK_DIV-1; a one-clock divider still needs one bit.
  localparam int            DivW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
  localparam logic [7:0]    MaxDuty = 8'(MAX_DUTY);
  localparam logic [8:0]    StepAmt = 9'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    STOP = 2'd3
  } rampStateT;

  rampStateT       state;
  logic [7:0]      target;
  logic [7:0]      duty;
  logic [DivW-1:0] divCount;
  logic            doneFlag;

  logic            stepTick;
  logic            capture;
  logic [7:0]      clampedTarget;
  logic [8:0]      upSum;
  logic [7:0]      upNext;
  logic signed [8:0] downDiff;
  logic [7:0]      downNext;

  // Step strobe, capture qualification and the clamped/limited next duty values.
  // Capture is suppressed in STOP so the release edge always lands at target 0.
  always_comb begin
    stepTick      = (divCount == DivLast);
    capture       = target_valid && estop_InLow && (state != STOP);
    clampedTarget = (target_duty > MaxDuty) ? MaxDuty : target_duty;

    // Upward step: 9-bit sum so duty+STEP near 255 cannot wrap, then cap at target.
    upSum  = {1'b0, duty} + StepAmt;
    upNext = (upSum >= {1'b0, target}) ? target : upSum[7:0];

    // Downward step: signed difference so duty-STEP below zero stays negative,
    // then floor at target (which is never below 0).
    downDiff = $signed({1'b0, duty}) - $signed(StepAmt);
    downNext = (downDiff <= $signed({1'b0, target})) ? target : downDiff[7:0];
  end

  // Free-running step divider; restarts on every capture so the first step lands
  // a full TICK_DIV clocks after the new target, and is held at 0 during estop.
  always_ff @(posedge clock or negedge reset_InLow) begin
    if (!reset_InLow) begin
      divCount <= '0;
    end else if (!estop_InLow || capture || stepTick) begin
      divCount <= '0;
    end else begin
      divCount <= divCount + DivW'(1);
    end
  end

  // Target register: clamped on capture, zeroed by estop.
  always_ff @(posedge clock or negedge reset_InLow) begin
    if (!reset_InLow) begin
      target <= '0;
    end else if (!estop_InLow) begin
      target <= '0;
    end else if (capture) begin
      target <= clampedTarget;
    end
  end

  // Ramp FSM: owns state, the registered duty and the done pulse.
  // A capture edge freezes the FSM; the following edge re-evaluates direction
  // against the new target, so a reversal never moves duty until the next tick.
  always_ff @(posedge clock or negedge reset_InLow) begin
    if (!reset_InLow) begin
      state    <= IDLE;
      duty     <= '0;
      doneFlag <= 1'b0;
    end else if (!estop_InLow) begin
      state    <= STOP;
      duty     <= '0;
      doneFlag <= 1'b0;
    end else begin
      doneFlag <= 1'b0;
      unique case (state)
        STOP: begin
          state <= IDLE;
        end
        IDLE: begin
          if (!capture) begin
            if (target > duty)      state <= UP;
            else if (target < duty) state <= DOWN;
          end
        end
        UP: begin
          if (!capture) begin
            if (target > duty) begin
              if (stepTick) begin
                duty <= upNext;
                if (upNext == target) begin
                  state    <= IDLE;
                  doneFlag <= 1'b1;
                end
              end
            end else begin
              // Retargeted at or below the current duty: turn around or settle.
              state <= (target < duty) ? DOWN : IDLE;
            end
          end
        end
        DOWN: begin
          if (!capture) begin
            if (target < duty) begin
              if (stepTick) begin
                duty <= downNext;
                if (downNext == target) begin
                  state    <= IDLE;
                  doneFlag <= 1'b1;
                end
              end
            end else begin
              state <= (target > duty) ? UP : IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  assign duty_out = duty;
  assign busy     = (state == UP) || (state == DOWN);
  assign done     = doneFlag;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: directed scenarios plus a randomized run, all checked
// against an event-level model of the ramp rules (target, duty, cycles since the
// last divider restart, ramping flag).
module tb_pwm_duty_ramp;

  localparam int TD = 4;
  localparam int ST = 2;
  localparam int MX = 249;

  logic       clock;
  logic       reset_InLow;
  logic       target_valid;
  logic [7:0] target_duty;
  logic       estop_InLow;
  logic [7:0] duty_out;
  logic       busy;
  logic       done;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int mDuty, mTarget, mCnt;
  bit mBusy, mDone, mStop;

  pwm_duty_ramp #(.TICK_DIV(TD), .STEP(ST), .MAX_DUTY(MX)) dut (
    .clock(clock),
    .reset_InLow(reset_InLow),
    .target_valid(target_valid),
    .target_duty(target_duty),
    .estop_InLow(estop_InLow),
    .duty_out(duty_out),
    .busy(busy),
    .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic modelZero();
    mDuty = 0; mTarget = 0; mCnt = 0; mBusy = 0; mDone = 0; mStop = 0;
  endtask

  // One rising edge of the reference behaviour, using the inputs present at the edge.
  task automatic modelStep();
    bit tick;
    if (!reset_InLow) begin
      modelZero();
    end else if (!estop_InLow) begin
      mDuty = 0; mTarget = 0; mCnt = 0; mBusy = 0; mDone = 0; mStop = 1;
    end else if (mStop) begin
      mStop = 0; mBusy = 0; mDone = 0; mCnt = (mCnt + 1) % TD;
    end else if (target_valid) begin
      mTarget = (int'(target_duty) > MX) ? MX : int'(target_duty);
      mCnt = 0; mDone = 0;
    end else begin
      tick  = (mCnt == TD - 1);
      mDone = 0;
      if (mBusy && tick && mTarget != mDuty) begin
        if (mTarget > mDuty) mDuty = (mDuty + ST > mTarget) ? mTarget : mDuty + ST;
        else                 mDuty = (mDuty - ST < mTarget) ? mTarget : mDuty - ST;
        if (mDuty == mTarget) begin mBusy = 0; mDone = 1; end
      end else begin
        mBusy = (mTarget != mDuty);
      end
      mCnt = (mCnt + 1) % TD;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    modelStep();
    @(negedge clock);
  endtask

  task automatic applyReset();
    reset_InLow = 1'b0;
    cyc();
    reset_InLow = 1'b1;
  endtask

  task automatic strobe(input int value);
    target_valid = 1'b1;
    target_duty  = 8'(value);
    cyc();
    target_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    compared++;
    if (duty_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_hold: duty=%0d busy=%0b done=%0b, expected 0/0/0", duty_out, busy, done);
    end
    repeat (3) cyc();
    reset_InLow = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      compared++;
      if (duty_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_idle cyc%0d: duty=%0d busy=%0b done=%0b, expected 0/0/0", i, duty_out, busy, done);
      end
    end
  endtask

  task automatic test_ramp_up();
    int doneCount = 0;
    int seqIdx = 0;
    int prevDuty = 0;
    strobe(10);
    for (int k = 1; k <= 30; k++) begin
      cyc();
      compared++;
      if (duty_out !== 8'(mDuty) || busy !== mBusy || done !== mDone) begin
        mismatched++;
        $display("FAIL ramp_up model k=%0d: duty=%0d busy=%0b done=%0b, expected %0d/%0b/%0b",
                 k, duty_out, busy, done, mDuty, mBusy, mDone);
      end
      // Steps land at 4,8,12,16,20 clocks after the strobe edge.
      compared++;
      if (int'(duty_out) != ((k >= 20) ? 10 : 2 * (k / 4))) begin
        mismatched++;
        $display("FAIL ramp_up timing k=%0d: duty=%0d, expected %0d", k, duty_out, (k >= 20) ? 10 : 2 * (k / 4));
      end
      if (k >= 1 && k < 20) begin
        compared++;
        if (busy !== 1'b1) begin
          mismatched++;
          $display("FAIL ramp_up busy k=%0d: busy=%0b, expected 1", k, busy);
        end
      end
      if (done === 1'b1) begin
        doneCount++;
        compared++;
        if (duty_out !== 8'd10) begin
          mismatched++;
          $display("FAIL ramp_up done_duty: duty=%0d, expected 10", duty_out);
        end
      end
      if (int'(duty_out) != prevDuty) begin seqIdx++; prevDuty = int'(duty_out); end
    end
    compared++;
    if (doneCount != 1 || seqIdx != 5 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL ramp_up summary: done_pulses=%0d steps=%0d busy=%0b, expected 1/5/0", doneCount, seqIdx, busy);
    end
  endtask

  task automatic test_clamp();
    int doneCount = 0;
    int maxSeen = 0;
    strobe(255);
    for (int k = 0; k < 520; k++) begin
      cyc();
      compared++;
      if (duty_out !== 8'(mDuty) || busy !== mBusy || done !== mDone) begin
        mismatched++;
        $display("FAIL clamp model k=%0d: duty=%0d busy=%0b done=%0b, expected %0d/%0b/%0b",
                 k, duty_out, busy, done, mDuty, mBusy, mDone);
      end
      if (int'(duty_out) > maxSeen) maxSeen = int'(duty_out);
      if (done === 1'b1) doneCount++;
    end
    compared++;
    if (maxSeen != 249 || doneCount != 1 || duty_out !== 8'd249 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL clamp summary: max=%0d done_pulses=%0d final=%0d busy=%0b, expected 249/1/249/0",
               maxSeen, doneCount, duty_out, busy);
    end
  endtask

  task automatic test_reverse();
    int waited = 0;
    int expDuty;
    applyReset();
    strobe(20);
    while (duty_out !== 8'd6 && waited < 60) begin cyc(); waited++; end
    compared++;
    if (duty_out !== 8'd6) begin
      mismatched++;
      $display("FAIL reverse reach6: duty=%0d after %0d cycles, expected 6", duty_out, waited);
    end
    strobe(0);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      expDuty = (k < 4) ? 6 : (k < 8) ? 4 : (k < 12) ? 2 : 0;
      compared++;
      if (int'(duty_out) != expDuty || done !== (k == 12) || busy !== (k < 12)) begin
        mismatched++;
        $display("FAIL reverse k=%0d: duty=%0d done=%0b busy=%0b, expected %0d/%0b/%0b",
                 k, duty_out, done, busy, expDuty, k == 12, k < 12);
      end
      compared++;
      if (duty_out !== 8'(mDuty) || busy !== mBusy || done !== mDone) begin
        mismatched++;
        $display("FAIL reverse model k=%0d: duty=%0d busy=%0b done=%0b, expected %0d/%0b/%0b",
                 k, duty_out, busy, done, mDuty, mBusy, mDone);
      end
    end
  endtask

  task automatic test_estop();
    int waited = 0;
    applyReset();
    strobe(200);
    while (duty_out !== 8'd100 && waited < 300) begin cyc(); waited++; end
    compared++;
    if (duty_out !== 8'd100 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL estop reach100: duty=%0d busy=%0b, expected 100/1", duty_out, busy);
    end
    estop_InLow = 1'b0;
    cyc();
    compared++;
    if (duty_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL estop_enter: duty=%0d busy=%0b done=%0b, expected 0/0/0", duty_out, busy, done);
    end
    strobe(50);
    repeat (3) cyc();
    compared++;
    if (duty_out !== 8'd0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL estop_ignore_strobe: duty=%0d busy=%0b, expected 0/0", duty_out, busy);
    end
    estop_InLow = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      compared++;
      if (duty_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0 ||
          duty_out !== 8'(mDuty) || busy !== mBusy) begin
        mismatched++;
        $display("FAIL estop_release k=%0d: duty=%0d busy=%0b done=%0b, expected 0/0/0", k, duty_out, busy, done);
      end
    end
  endtask

  task automatic test_async_reset();
    int waited = 0;
    int doneCount = 0;
    applyReset();
    strobe(80);
    while (duty_out !== 8'd40 && waited < 200) begin cyc(); waited++; end
    compared++;
    if (duty_out !== 8'd40 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL async_reach40: duty=%0d busy=%0b, expected 40/1", duty_out, busy);
    end
    // Pulse reset strictly between edges and look before the next rising edge.
    #1 reset_InLow = 1'b0;
    #1;
    modelZero();
    compared++;
    if (duty_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: duty=%0d busy=%0b done=%0b, expected 0/0/0", duty_out, busy, done);
    end
    #1 reset_InLow = 1'b1;
    cyc();
    strobe(6);
    for (int k = 0; k < 20; k++) begin
      cyc();
      compared++;
      if (duty_out !== 8'(mDuty) || busy !== mBusy || done !== mDone) begin
        mismatched++;
        $display("FAIL async_restart model k=%0d: duty=%0d busy=%0b done=%0b, expected %0d/%0b/%0b",
                 k, duty_out, busy, done, mDuty, mBusy, mDone);
      end
      if (done === 1'b1) doneCount++;
    end
    compared++;
    if (duty_out !== 8'd6 || doneCount != 1) begin
      mismatched++;
      $display("FAIL async_restart final: duty=%0d done_pulses=%0d, expected 6/1", duty_out, doneCount);
    end
  endtask

  task automatic test_random();
    int stopLeft = 0;
    int errs = 0;
    applyReset();
    for (int k = 0; k < 3000; k++) begin
      target_valid = ($urandom_range(0, 15) == 0);
      target_duty  = 8'($urandom_range(0, 255));
      if (stopLeft > 0) begin
        stopLeft--;
        estop_InLow = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        stopLeft    = $urandom_range(0, 4);
        estop_InLow = 1'b0;
      end else begin
        estop_InLow = 1'b1;
      end
      cyc();
      compared++;
      if (duty_out !== 8'(mDuty) || busy !== mBusy || done !== mDone) begin
        mismatched++;
        if (errs < 10)
          $display("FAIL random k=%0d: duty=%0d busy=%0b done=%0b, expected %0d/%0b/%0b",
                   k, duty_out, busy, done, mDuty, mBusy, mDone);
        errs++;
      end
    end
    target_valid = 1'b0;
    estop_InLow  = 1'b1;
  endtask

  initial begin
    reset_InLow  = 1'b0;
    target_valid = 1'b0;
    target_duty  = 8'd0;
    estop_InLow  = 1'b1;
    modelZero();
    test_reset();
    test_ramp_up();
    test_clamp();
    test_reverse();
    test_estop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
